ahb_decoder_mux: RTL and testbench

- Parametrised AHB-Lite address decoder and slave-to-master response multiplexer for a single-master bus with NUM_SLAVES slaves plus a built-in default slave.
- Generates one-hot HSEL from per-slave base/mask regions in the address phase.
- Registers the selected slave for the data phase and muxes HRDATA/HREADY/HRESP back to the master.
- Unmapped NONSEQ/SEQ accesses receive the standard two-cycle ERROR response from the internal default slave.

---
 rtl/ahb_decoder_mux.sv | 104 ++++++++++
 tb/tb_ahb_decoder_mux.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder plus response mux with a built-in two-cycle ERROR default slave.
// Zero added latency on the response path; wait states from the selected slave freeze the data-phase register and the default-slave FSM.
module ahb_decoder_mux #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
        {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {4{32'hC000_0000}},
    parameter int IDX_W      = $clog2(NUM_SLAVES + 1)
) (
    input  logic                         hclk,
    input  logic                         hrst,
    input  logic [ADDR_W-1:0]            haddr,
    input  logic [1:0]                   htrans,
    output logic [NUM_SLAVES-1:0]        hsel,
    output logic [IDX_W-1:0]             sel,
    input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
    input  logic [NUM_SLAVES-1:0]        hreadyout_s,
    input  logic [NUM_SLAVES-1:0]        hresp_s,
    output logic [DATA_W-1:0]            hrdata,
    output logic                         hready,
    output logic                         hresp
);

    localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(NUM_SLAVES);

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_t;

    ds_state_t        ds_q, ds_d;
    logic [IDX_W-1:0] dp_idx_q, dp_idx_d;
    logic             dp_act_q, dp_act_d;
    logic             hit;
    logic             unmapped_req;

    // Lowest matching index wins, so the first hit blocks later ones.
    always_comb begin
        hsel = '0;
        sel  = DEF_IDX;
        hit  = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((haddr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                         (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]))) begin
                hit     = 1'b1;
                hsel[i] = 1'b1;
                sel     = IDX_W'(i);
            end
        end
    end

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        if (dp_act_q) begin
            if (dp_idx_q == DEF_IDX) begin
                hready = (ds_q != DS_ERR1);
                hresp  = (ds_q != DS_IDLE);
            end else begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (dp_idx_q == IDX_W'(i)) begin
                        hrdata = hrdata_s[i*DATA_W +: DATA_W];
                        hready = hreadyout_s[i];
                        hresp  = hresp_s[i];
                    end
                end
            end
        end
    end

    always_comb begin
        dp_idx_d     = dp_idx_q;
        dp_act_d     = dp_act_q;
        ds_d         = ds_q;
        unmapped_req = hready && htrans[1] && (sel == DEF_IDX);
        if (hready) begin
            dp_idx_d = sel;
            dp_act_d = htrans[1];
        end
        case (ds_q)
            DS_IDLE: if (unmapped_req) ds_d = DS_ERR1;
            DS_ERR1: ds_d = DS_ERR2;
            DS_ERR2: ds_d = unmapped_req ? DS_ERR1 : DS_IDLE;
            default: ds_d = DS_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            dp_idx_q <= '0;
            dp_act_q <= 1'b0;
            ds_q     <= DS_IDLE;
        end else begin
            dp_idx_q <= dp_idx_d;
            dp_act_q <= dp_act_d;
            ds_q     <= ds_d;
        end
    end

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Bench for ahb_decoder_mux: default map (a), overlapping/narrowed map (b), single-slave map (c).
module tb_ahb_decoder_mux;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    localparam logic [127:0] B_BASE = {32'hC000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    localparam logic [127:0] B_MASK = {32'hFFFF_0000, 32'hC000_0000, 32'h8000_0000, 32'hC000_0000};

    logic         hclk, hrst;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic [127:0] hrdata_s;
    logic [3:0]   hreadyout_s, hresp_s;

    logic [3:0]  hsel_a, hsel_b;
    logic [2:0]  sel_a, sel_b;
    logic [31:0] hrdata_a, hrdata_b, hrdata_c;
    logic        hready_a, hready_b, hready_c, hresp_a, hresp_b, hresp_c;
    logic        hsel_c, sel_c;

    int checks, failures;

    ahb_decoder_mux dut_a (
        .hclk(hclk), .hrst(hrst), .haddr(haddr), .htrans(htrans),
        .hsel(hsel_a), .sel(sel_a), .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s),
        .hresp_s(hresp_s), .hrdata(hrdata_a), .hready(hready_a), .hresp(hresp_a)
    );

    ahb_decoder_mux #(.SLV_BASE(B_BASE), .SLV_MASK(B_MASK)) dut_b (
        .hclk(hclk), .hrst(hrst), .haddr(haddr), .htrans(htrans),
        .hsel(hsel_b), .sel(sel_b), .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s),
        .hresp_s(hresp_s), .hrdata(hrdata_b), .hready(hready_b), .hresp(hresp_b)
    );

    ahb_decoder_mux #(.NUM_SLAVES(1), .SLV_BASE(32'h0000_0000), .SLV_MASK(32'h8000_0000)) dut_c (
        .hclk(hclk), .hrst(hrst), .haddr(haddr), .htrans(htrans),
        .hsel(hsel_c), .sel(sel_c), .hrdata_s(hrdata_s[31:0]), .hreadyout_s(hreadyout_s[0]),
        .hresp_s(hresp_s[0]), .hrdata(hrdata_c), .hready(hready_c), .hresp(hresp_c)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Reference model: address map as tables, pending data phase as a transfer record.
    function automatic int num_slv(input int c);
        return (c == 2) ? 1 : 4;
    endfunction

    function automatic int decode(input int c, input logic [31:0] a);
        logic [31:0] b, m;
        for (int i = 0; i < num_slv(c); i++) begin
            case (c)
                0:       begin b = 32'h4000_0000 * i; m = 32'hC000_0000; end
                1:       begin b = B_BASE[i*32 +: 32]; m = B_MASK[i*32 +: 32]; end
                default: begin b = 32'h0; m = 32'h8000_0000; end
            endcase
            if ((a & m) == (b & m)) return i;
        end
        return num_slv(c);
    endfunction

    int          m_act [3];
    int          m_idx [3];
    int          m_err [3];
    logic        e_rdy [3];
    logic        e_resp[3];
    logic [31:0] e_data[3];

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            e_rdy[c]  = 1'b1;
            e_resp[c] = 1'b0;
            e_data[c] = 32'h0;
            if (m_act[c] != 0) begin
                if (m_idx[c] < num_slv(c)) begin
                    e_rdy[c]  = hreadyout_s[m_idx[c]];
                    e_resp[c] = hresp_s[m_idx[c]];
                    e_data[c] = hrdata_s[m_idx[c]*32 +: 32];
                end else begin
                    e_rdy[c]  = (m_err[c] == 1);
                    e_resp[c] = 1'b1;
                end
            end
        end
    end

    always @(posedge hclk or posedge hrst) begin
        for (int c = 0; c < 3; c++) begin
            if (hrst) begin
                m_act[c] <= 0;
                m_idx[c] <= 0;
                m_err[c] <= 0;
            end else if (e_rdy[c]) begin
                m_act[c] <= int'(htrans[1]);
                m_idx[c] <= decode(c, haddr);
                m_err[c] <= 2;
            end else if (m_act[c] != 0 && m_idx[c] == num_slv(c)) begin
                m_err[c] <= m_err[c] - 1;
            end
        end
    end

    logic        o_rdy [3];
    logic        o_resp[3];
    logic [31:0] o_data[3];
    logic [4:0]  o_sel [3];
    logic [3:0]  o_hsel[3];
    assign o_rdy[0] = hready_a;  assign o_resp[0] = hresp_a;  assign o_data[0] = hrdata_a;
    assign o_rdy[1] = hready_b;  assign o_resp[1] = hresp_b;  assign o_data[1] = hrdata_b;
    assign o_rdy[2] = hready_c;  assign o_resp[2] = hresp_c;  assign o_data[2] = hrdata_c;
    assign o_sel[0] = {2'b0, sel_a}; assign o_sel[1] = {2'b0, sel_b}; assign o_sel[2] = {4'b0, sel_c};
    assign o_hsel[0] = hsel_a; assign o_hsel[1] = hsel_b; assign o_hsel[2] = {3'b0, hsel_c};

    // Inputs change 1ns after the rising edge; outputs are looked at 4ns after it.
    task automatic step(input logic [31:0] a, input logic [1:0] t, input logic [3:0] rdy);
        @(posedge hclk);
        #1;
        haddr       = a;
        htrans      = t;
        hreadyout_s = rdy;
        #3;
    endtask

    task automatic test_reset;
        #1 hrst = 1'b1;
        #2;
        checks++;
        if (hready_a !== 1'b1 || hresp_a !== 1'b0 || hrdata_a !== 32'h0) begin
            failures++;
            $display("FAIL reset_out: got rdy=%b resp=%b data=%h want 1 0 0", hready_a, hresp_a, hrdata_a);
        end
        haddr = 32'h8000_0004;
        #1;
        checks++;
        if (hsel_a !== 4'b0100 || sel_a !== 3'd2) begin
            failures++;
            $display("FAIL reset_decode: got hsel=%b sel=%0d want 0100 2", hsel_a, sel_a);
        end
        step(32'h0, IDLE, 4'hF);
        hrst = 1'b0;
        step(32'h0, IDLE, 4'hF);
        checks++;
        if (hready_a !== 1'b1 || hresp_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got rdy=%b resp=%b want 1 0", hready_a, hresp_a);
        end
    endtask

    task automatic test_reset_mid;
        step(32'h8000_0000, NONSEQ, 4'hF);
        step(32'h0, IDLE, 4'b1011);
        checks++;
        if (hready_a !== 1'b0 || hrdata_a !== 32'hA5A5_0002) begin
            failures++;
            $display("FAIL reset_mid_wait: got rdy=%b data=%h want 0 a5a50002", hready_a, hrdata_a);
        end
        #1 hrst = 1'b1;
        #1;
        checks++;
        if (hready_a !== 1'b1 || hresp_a !== 1'b0 || hrdata_a !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_out: got rdy=%b resp=%b data=%h want 1 0 0", hready_a, hresp_a, hrdata_a);
        end
        step(32'h0, IDLE, 4'b1011);
        hrst = 1'b0;
        step(32'h0, IDLE, 4'hF);
        checks++;
        if (hready_a !== 1'b1 || hresp_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle: got rdy=%b resp=%b want 1 0", hready_a, hresp_a);
        end
    endtask

    task automatic test_decode_sweep;
        logic [31:0] addrs [4] = '{32'h0000_0010, 32'h4000_0000, 32'h8000_0004, 32'hFFFF_FFFC};
        for (int k = 0; k < 5; k++) begin
            if (k < 4) step(addrs[k], NONSEQ, 4'hF);
            else       step(32'h0, IDLE, 4'hF);
            if (k < 4) begin
                checks++;
                if (hsel_a !== 4'(1 << k) || sel_a !== 3'(k)) begin
                    failures++;
                    $display("FAIL sweep_decode_%0d: got hsel=%b sel=%0d want %b %0d", k, hsel_a, sel_a, 4'(1 << k), k);
                end
            end
            if (k > 0) begin
                checks++;
                if (hrdata_a !== (32'hA5A5_0000 | 32'(k - 1)) || hready_a !== 1'b1) begin
                    failures++;
                    $display("FAIL sweep_data_%0d: got data=%h rdy=%b want %h 1", k, hrdata_a, hready_a, 32'hA5A5_0000 | 32'(k - 1));
                end
            end
        end
    endtask

    task automatic test_wait_state;
        step(32'h4000_0000, NONSEQ, 4'hF);
        for (int k = 0; k < 3; k++) begin
            step(32'h0000_0010, NONSEQ, 4'b1101);
            checks++;
            if (hready_a !== 1'b0 || hrdata_a !== 32'hA5A5_0001 || hsel_a !== 4'b0001) begin
                failures++;
                $display("FAIL wait_hold_%0d: got rdy=%b data=%h hsel=%b want 0 a5a50001 0001", k, hready_a, hrdata_a, hsel_a);
            end
        end
        step(32'h0000_0010, NONSEQ, 4'hF);
        checks++;
        if (hready_a !== 1'b1 || hrdata_a !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL wait_release: got rdy=%b data=%h want 1 a5a50001", hready_a, hrdata_a);
        end
        step(32'h0, IDLE, 4'hF);
        checks++;
        if (hrdata_a !== 32'hA5A5_0000) begin
            failures++;
            $display("FAIL wait_next: got data=%h want a5a50000", hrdata_a);
        end
    endtask

    task automatic test_unmapped;
        step(32'hD000_0000, NONSEQ, 4'hF);
        checks++;
        if (sel_b !== 3'd4 || hsel_b !== 4'b0000) begin
            failures++;
            $display("FAIL unmapped_decode: got sel=%0d hsel=%b want 4 0000", sel_b, hsel_b);
        end
        step(32'h0, IDLE, 4'hF);
        checks++;
        if (hready_b !== 1'b0 || hresp_b !== 1'b1 || hrdata_b !== 32'h0) begin
            failures++;
            $display("FAIL unmapped_err1: got rdy=%b resp=%b data=%h want 0 1 0", hready_b, hresp_b, hrdata_b);
        end
        step(32'h0, IDLE, 4'hF);
        checks++;
        if (hready_b !== 1'b1 || hresp_b !== 1'b1) begin
            failures++;
            $display("FAIL unmapped_err2: got rdy=%b resp=%b want 1 1", hready_b, hresp_b);
        end
        step(32'hD000_0000, IDLE, 4'hF);
        step(32'h0, IDLE, 4'hF);
        checks++;
        if (hready_b !== 1'b1 || hresp_b !== 1'b0) begin
            failures++;
            $display("FAIL unmapped_idle: got rdy=%b resp=%b want 1 0", hready_b, hresp_b);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ta [16] = '{32'hD000_0000, 32'h0000_0004, 32'h0000_0004, 32'h0,
                                 32'hD000_0000, 32'hD000_0000, 32'hD000_0004, 32'h0, 32'h0, 32'h0,
                                 32'h8000_0000, 32'hD000_0000, 32'hD000_0000, 32'h0, 32'h0, 32'h0};
        logic [1:0]  tt [16] = '{NONSEQ, SEQ, SEQ, IDLE, NONSEQ, NONSEQ, NONSEQ, IDLE, IDLE, IDLE,
                                 NONSEQ, NONSEQ, NONSEQ, IDLE, IDLE, IDLE};
        logic [3:0]  tr [16] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                 4'hF, 4'b1011, 4'hF, 4'hF, 4'hF, 4'hF};
        logic        xr [16] = '{1, 0, 1, 1, 1, 0, 1, 0, 1, 1, 1, 0, 1, 0, 1, 1};
        logic        xp [16] = '{0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0};
        logic [31:0] xd [16] = '{32'h0, 32'h0, 32'h0, 32'hA5A5_0000, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h0, 32'hA5A5_0002, 32'hA5A5_0002, 32'h0, 32'h0, 32'h0};
        for (int k = 0; k < 16; k++) begin
            step(ta[k], tt[k], tr[k]);
            checks++;
            if (hready_b !== xr[k] || hresp_b !== xp[k] || hrdata_b !== xd[k]) begin
                failures++;
                $display("FAIL b2b_%0d: got rdy=%b resp=%b data=%h want %b %b %h",
                         k, hready_b, hresp_b, hrdata_b, xr[k], xp[k], xd[k]);
            end
        end
    endtask

    task automatic test_overlap;
        step(32'h0000_0100, NONSEQ, 4'hF);
        checks++;
        if (hsel_b !== 4'b0001 || sel_b !== 3'd0) begin
            failures++;
            $display("FAIL overlap_low: got hsel=%b sel=%0d want 0001 0", hsel_b, sel_b);
        end
        step(32'h4000_0100, NONSEQ, 4'hF);
        checks++;
        if (hsel_b !== 4'b0010 || sel_b !== 3'd1) begin
            failures++;
            $display("FAIL overlap_high: got hsel=%b sel=%0d want 0010 1", hsel_b, sel_b);
        end
        step(32'h0, IDLE, 4'hF);
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [3:0]  rdy;
        int          exp_sel;
        for (int n = 0; n < 600; n++) begin
            @(posedge hclk);
            #1;
            case ($urandom_range(0, 5))
                0:       a = $urandom;
                1:       a = 32'hD000_0000 | ($urandom & 32'h0000_FFFC);
                2:       a = 32'hC000_0000 | ($urandom & 32'h0000_FFFC);
                3:       a = $urandom & 32'h0000_0FFC;
                4:       a = 32'h4000_0000 | ($urandom & 32'h3FFF_FFFC);
                default: a = 32'h8000_0000 | ($urandom & 32'h3FFF_FFFC);
            endcase
            haddr  = a;
            htrans = 2'($urandom);
            for (int i = 0; i < 4; i++) rdy[i] = ($urandom_range(0, 3) != 0);
            hreadyout_s = rdy;
            hresp_s     = 4'($urandom) & 4'($urandom);
            hrdata_s    = {$urandom, $urandom, $urandom, $urandom};
            hrst        = ($urandom_range(0, 79) == 0);
            #3;
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (o_rdy[c] !== e_rdy[c] || o_resp[c] !== e_resp[c] || o_data[c] !== e_data[c]) begin
                    failures++;
                    $display("FAIL rand_resp dut%0d cyc%0d: got rdy=%b resp=%b data=%h want %b %b %h",
                             c, n, o_rdy[c], o_resp[c], o_data[c], e_rdy[c], e_resp[c], e_data[c]);
                end
                exp_sel = decode(c, haddr);
                checks++;
                if (o_sel[c] !== 5'(exp_sel) ||
                    o_hsel[c] !== ((exp_sel < num_slv(c)) ? 4'(1 << exp_sel) : 4'b0)) begin
                    failures++;
                    $display("FAIL rand_decode dut%0d cyc%0d: got sel=%0d hsel=%b want sel=%0d",
                             c, n, o_sel[c], o_hsel[c], exp_sel);
                end
            end
        end
        hrst = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        hrst        = 1'b0;
        haddr       = 32'h0;
        htrans      = IDLE;
        hreadyout_s = 4'hF;
        hresp_s     = 4'h0;
        hrdata_s    = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
        test_reset;
        test_reset_mid;
        test_decode_sweep;
        test_wait_state;
        test_unmapped;
        test_back_to_back;
        test_overlap;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
